// File: rtl/fetch_unit.sv
// fetch_unit: two-state instruction fetch FSM; FETCH_TIMEOUT_EN adds a bounded mem_ack wait
module fetch_unit #(
    parameter int ADDR_WIDTH     = 16,
    parameter int INSTR_WIDTH    = 16,
    parameter int RESET_PC       = 0,
    parameter int TIMEOUT_CYCLES = 15,
    localparam int NIB_WIDTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   do_fetch,
    input  logic                   do_next,
    input  logic                   jump_en,
    input  logic [ADDR_WIDTH-1:0]  jump_target,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [NIB_WIDTH-1:0]   opcode,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   busy,
    output logic                   fetch_done,
    output logic                   fetch_err
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d, mem_addr_q, mem_addr_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   mem_req_q, mem_req_d, done_q, done_d, err_q, err_d;
    logic                   timeout;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign timeout = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign cnt_d   = (state_q == WAIT && !mem_ack) ? cnt_q + CW'(1) : '0;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = do_next ? (jump_en ? jump_target : pc_q + ADDR_WIDTH'(1)) : pc_q;
        instr_d    = instr_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        done_d     = 1'b0;
        err_d      = err_q;
        if (state_q == IDLE) begin
            if (do_fetch) begin
                state_d    = WAIT;
                mem_req_d  = 1'b1;
                mem_addr_d = pc_q;
            end
        end else begin
            if (do_fetch) err_d = 1'b1;
            if (mem_ack || timeout) begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                done_d    = 1'b1;
                instr_d   = mem_ack ? mem_rdata : '0;
                if (!mem_ack) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= ADDR_WIDTH'(RESET_PC);
            instr_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign instr      = instr_q;
    assign opcode     = instr_q[INSTR_WIDTH-1 -: NIB_WIDTH];
    assign pc         = pc_q;
    assign busy       = (state_q == WAIT);
    assign fetch_done = done_q;
    assign fetch_err  = err_q;
endmodule
